block_row_drawer: RTL

- Downstream stage of the block position/colour loader: converts the loader's top-left block coordinate, colour and row width into a pixel stream for the 160x120 VGA adapter.
- On a start pulse it latches one block row (N blocks of BLOCK_SIZE x BLOCK_SIZE pixels) and emits one pixel per clock, with a plot strobe.
- Off-screen pixels are clipped.
- Finishes with a one-cycle done pulse so the game control FSM can sequence erase/draw passes.

---
 rtl/block_row_drawer_if.sv | 24 ++
 rtl/block_row_drawer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/block_row_drawer_if.sv
// rtl/block_row_drawer_if.sv - row request and pixel stream bundle between loader, drawer and VGA adapter
interface block_row_drawer_if;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [3:0] blocks_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, x_in, y_in, colour_in, blocks_in,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, x_in, y_in, colour_in, blocks_in,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/block_row_drawer.sv
// rtl/block_row_drawer.sv - expands one row of square blocks into a clipped pixel stream
module block_row_drawer #(
    parameter int BLOCK_SIZE = 4,
    parameter int MAX_BLOCKS = 8,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic               clk,
    input  logic               reset,
    block_row_drawer_if.slave  bus
);
    // cx must hold the full row span so the last-column compare never aliases
    localparam int CX_W   = $clog2(MAX_BLOCKS * BLOCK_SIZE + 1);
    localparam int CY_W   = $clog2(BLOCK_SIZE + 1);
    localparam int BS_LOG = $clog2(BLOCK_SIZE);
    localparam logic [3:0]      MAX_B   = 4'(MAX_BLOCKS);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(BLOCK_SIZE - 1);
    localparam logic [8:0]      LIM_X   = 9'(SCREEN_W);
    localparam logic [7:0]      LIM_Y   = 8'(SCREEN_H);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      x0;
    logic [6:0]      y0;
    logic [2:0]      c0;
    logic [CX_W-1:0] span_last;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            fin;
    logic [3:0]      n_sat;
    logic [CX_W-1:0] span_last_d;
    logic [8:0]      x_sum;
    logic [7:0]      y_sum;

    // Row length clamp: zero still draws one block, oversize saturates
    always_comb begin
        n_sat = bus.blocks_in;
        if (bus.blocks_in == 4'd0) begin
            n_sat = 4'd1;
        end else if (bus.blocks_in > MAX_B) begin
            n_sat = MAX_B;
        end
        span_last_d = (CX_W'(n_sat) << BS_LOG) - CX_W'(1);
    end

    // Pixel coordinate with one extra bit so overflow clips instead of wrapping
    always_comb begin
        x_sum = {1'b0, x0} + 9'(cx);
        y_sum = {1'b0, y0} + 8'(cy);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fin marks that the last pixel is already on the outputs
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_DRAW;
            S_DRAW:  if (fin) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Row latch, scan counters and registered pixel outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0             <= '0;
            y0             <= '0;
            c0             <= '0;
            span_last      <= '0;
            cx             <= '0;
            cy             <= '0;
            fin            <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
            bus.plot       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.plot <= 1'b0;
                    bus.done <= 1'b0;
                    fin      <= 1'b0;
                    if (bus.start) begin
                        x0        <= bus.x_in;
                        y0        <= bus.y_in;
                        c0        <= bus.colour_in;
                        span_last <= span_last_d;
                        cx        <= '0;
                        cy        <= '0;
                        bus.busy  <= 1'b1;
                    end else begin
                        bus.busy  <= 1'b0;
                    end
                end
                S_DRAW: begin
                    bus.busy <= 1'b1;
                    if (fin) begin
                        bus.plot <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        bus.x_out      <= x_sum[7:0];
                        bus.y_out      <= y_sum[6:0];
                        bus.colour_out <= c0;
                        bus.plot       <= (x_sum < LIM_X) && (y_sum < LIM_Y);
                        if (cx == span_last) begin
                            cx <= '0;
                            if (cy == CY_LAST) begin
                                fin <= 1'b1;
                            end else begin
                                cy <= cy + CY_W'(1);
                            end
                        end else begin
                            cx <= cx + CX_W'(1);
                        end
                    end
                end
                default: begin
                    bus.plot <= 1'b0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    fin      <= 1'b0;
                end
            endcase
        end
    end
endmodule
